// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder: a template+immediate request
// channel and an encoded-instruction output channel, both valid/ready.
interface imm_encoder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_fmt;
  logic [DATA_WIDTH-1:0] req_base;
  logic [DATA_WIDTH-1:0] req_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic                  out_err;

  modport slave (
    input  req_valid, req_fmt, req_base, req_imm, out_ready,
    output req_ready, out_valid, out_inst, out_err
  );

  modport master (
    output req_valid, req_fmt, req_base, req_imm, out_ready,
    input  req_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: scatters an immediate into a template instruction word
// and expands LI into ADDI, LUI, or a LUI/ADDI pair behind one registered stage.
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter bit LI_ENABLE  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("imm_encoder supports DATA_WIDTH=32 only");
    end
  endgenerate

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_SHIFT = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_LI    = 3'd5;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FIRST = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] out_inst_reg, out_inst_next;
  logic        out_err_reg, out_err_next;
  logic [31:0] pending_reg, pending_next;

  logic [31:0] imm;
  logic [31:0] base;
  logic [4:0]  rd;
  logic        fits12, fits13, fits21, fits_shamt;
  logic [19:0] li_upper;
  logic [31:0] enc_word0, enc_word1;
  logic        enc_two, enc_err;
  logic        req_ready_int;
  logic        accept;

  assign imm  = bus.req_imm;
  assign base = bus.req_base;
  assign rd   = base[11:7];

  // A value fits signed N when every bit from N-1 upward equals the sign.
  assign fits12     = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13     = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21     = (&imm[31:20]) | ~(|imm[31:20]);
  assign fits_shamt = ~(|imm[31:5]);

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending its low 12 bits.
  assign li_upper = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    enc_word0 = base;
    enc_word1 = '0;
    enc_two   = 1'b0;
    enc_err   = 1'b0;
    case (bus.req_fmt)
      FMT_I: begin
        if (fits12) enc_word0 = {imm[11:0], base[19:0]};
        else        enc_err   = 1'b1;
      end
      FMT_SHIFT: begin
        if (fits_shamt) enc_word0 = {base[31:25], imm[4:0], base[19:0]};
        else            enc_err   = 1'b1;
      end
      FMT_S: begin
        if (fits12) enc_word0 = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        else        enc_err   = 1'b1;
      end
      FMT_B: begin
        if (fits13 && !imm[0])
          enc_word0 = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        else
          enc_err = 1'b1;
      end
      FMT_J: begin
        if (fits21 && !imm[0])
          enc_word0 = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        else
          enc_err = 1'b1;
      end
      FMT_LI: begin
        if (!LI_ENABLE) begin
          enc_err = 1'b1;
        end else if (fits12) begin
          enc_word0 = {imm[11:0], 5'd0, 3'b000, rd, OPC_OPIMM};
        end else begin
          enc_word0 = {li_upper, rd, OPC_LUI};
          if (|imm[11:0]) begin
            enc_two   = 1'b1;
            enc_word1 = {imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
          end
        end
      end
      default: enc_err = 1'b1;
    endcase
    // Rejected requests pass the template through untouched.
    if (enc_err) begin
      enc_word0 = base;
      enc_word1 = '0;
      enc_two   = 1'b0;
    end
  end

  always_comb begin
    req_ready_int = 1'b0;
    if (!rst) begin
      case (state_reg)
        EMPTY:   req_ready_int = 1'b1;
        ONE:     req_ready_int = bus.out_ready;
        default: req_ready_int = 1'b0;
      endcase
    end
  end

  assign accept = bus.req_valid & req_ready_int;

  always_comb begin
    state_next    = state_reg;
    out_inst_next = out_inst_reg;
    out_err_next  = out_err_reg;
    pending_next  = pending_reg;
    case (state_reg)
      EMPTY, ONE: begin
        if (accept) begin
          out_inst_next = enc_word0;
          out_err_next  = enc_err;
          pending_next  = enc_word1;
          state_next    = enc_two ? FIRST : ONE;
        end else if (state_reg == ONE && bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      FIRST: begin
        if (bus.out_ready) begin
          out_inst_next = pending_reg;
          out_err_next  = 1'b0;
          pending_next  = '0;
          state_next    = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      out_inst_reg <= '0;
      out_err_reg  <= 1'b0;
      pending_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      out_inst_reg <= out_inst_next;
      out_err_reg  <= out_err_next;
      pending_reg  <= pending_next;
    end
  end

  assign bus.req_ready = req_ready_int;
  assign bus.out_valid = (state_reg != EMPTY);
  assign bus.out_inst  = out_inst_reg;
  assign bus.out_err   = out_err_reg;

endmodule
